// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32 pipeline.
// Resolves branches and jumps, and runs loads and stores against an external
// data memory over a req/ready handshake. Upstream stages are held while an
// access is in flight. A timed-out or misaligned access raises mem_fault.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        jump,
  input  logic        jump_return,
  input  logic [1:0]  bType,
  input  logic        zero,
  input  logic        lt_zero,
  input  logic [31:0] branch_destination,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        asByte,
  input  logic        asUnsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] read_data_2,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        stall,
  output logic [31:0] mem_read_data,
  output logic        mem_fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  // The counter is wide enough for the largest legal TIMEOUT (1023).
  localparam int              CW     = 10;
  localparam logic [CW-1:0]   TO_LIM = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_q, load_d;
  logic          fault_q, fault_d;

  logic          cond;
  logic          mem_op;
  logic          misaligned;
  logic          access;
  logic          req;
  logic          fault_now;
  logic [7:0]    ld_byte;
  logic [31:0]   ld_ext;

  // Branch/jump resolution; purely combinational from EX/MEM.
  always_comb begin
    case (bType)
      2'b00:   cond = zero;
      2'b01:   cond = ~zero;
      2'b10:   cond = lt_zero;
      default: cond = ~lt_zero;
    endcase
    pc_src    = (branch & cond) | jump;
    pc_target = jump_return ? {alu_result[31:1], 1'b0} : branch_destination;
    flush     = pc_src;
  end

  // Access classification and load-lane extraction.
  always_comb begin
    mem_op     = memRead | memWrite;
    misaligned = mem_op & ~asByte & (alu_result[1:0] != 2'b00);
    access     = mem_op & ~misaligned;
    ld_byte    = dmem_rdata[{alu_result[1:0], 3'b000} +: 8];
    if (!asByte)         ld_ext = dmem_rdata;
    else if (asUnsigned) ld_ext = {24'b0, ld_byte};
    else                 ld_ext = {{24{ld_byte[7]}}, ld_byte};
  end

  // Access FSM: issue in IDLE, hold in WAIT, release the instruction in DONE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    load_d        = load_q;
    fault_d       = 1'b0;
    req           = 1'b0;
    stall         = 1'b0;
    fault_now     = 1'b0;
    mem_read_data = '0;
    case (state_q)
      S_IDLE: begin
        if (misaligned) begin
          fault_now = 1'b1;
        end else if (access) begin
          req   = 1'b1;
          stall = 1'b1;
          if (dmem_ready) begin
            state_d = S_DONE;
            if (!memWrite) load_d = ld_ext;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_ready) begin
          state_d = S_DONE;
          if (!memWrite) load_d = ld_ext;
        end else if (cnt_d == TO_LIM) begin
          state_d = S_DONE;
          fault_d = 1'b1;
          load_d  = '0;
        end
      end
      S_DONE: begin
        mem_read_data = load_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-side drive; everything is quiet unless a request is active.
  always_comb begin
    dmem_req   = req;
    dmem_we    = req & memWrite;
    dmem_addr  = req ? {alu_result[31:2], 2'b00} : 32'h0;
    dmem_wdata = 32'h0;
    dmem_wstrb = 4'b0000;
    if (req && memWrite) begin
      dmem_wdata = asByte ? {4{read_data_2[7:0]}} : read_data_2;
      dmem_wstrb = asByte ? (4'b0001 << alu_result[1:0]) : 4'b1111;
    end
    mem_fault = fault_now | fault_q;
  end

  // State registers; reset abandons any access in flight without a fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      load_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline. It sits between the EX/MEM and MEM/WB pipeline registers.
- Resolves conditional branches and jumps from the EX/MEM outputs and drives the PC redirect and flush.
- Performs loads and stores against an external data memory over a req/ready handshake, with byte/word sizing and sign/zero extension.
- Stalls the upstream pipeline while an access is in flight and supplies load data to MEM/WB.

Parameters:
- TIMEOUT, 255, maximum cycles spent in WAIT before the access is aborted; valid range 1..1023.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- branch  in  1  instruction is a conditional branch.
- jump  in  1  instruction is jal/jalr.
- jump_return  in  1  instruction is jalr; target = {alu_result[31:1],1'b0}.
- bType  in  2  branch condition: 00 beq, 01 bne, 10 blt, 11 bge.
- zero  in  1  ALU result equals zero.
- lt_zero  in  1  ALU signed-less-than flag.
- branch_destination  in  32  pc+imm target.
- memRead  in  1  load.
- memWrite  in  1  store.
- asByte  in  1  byte access; 0 = word access.
- asUnsigned  in  1  zero-extend a byte load (lbu).
- alu_result  in  32  effective address, or jalr base.
- read_data_2  in  32  store data (rs2).
- pc_src  out  1  redirect the PC this cycle.
- pc_target  out  32  redirect address.
- flush  out  1  squash the IF/ID and ID/EX contents.
- stall  out  1  hold the PC, IF/ID, ID/EX and EX/MEM registers; insert a bubble into MEM/WB.
- mem_read_data  out  32  extended load data for MEM/WB.
- mem_fault  out  1  one-cycle pulse on a misaligned word access or a timeout.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address, i.e. {alu_result[31:2],2'b00}.
- dmem_wdata  out  32  write data.
- dmem_wstrb  out  4  byte enables.
- dmem_rdata  in  32  read data; valid when dmem_ready is high.
- dmem_ready  in  1  access complete.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, timeout counter 0, load register 0, mem_fault 0. All outputs read 0 in the cycle after rst is sampled.
- Reset during WAIT: the access is abandoned. dmem_req is low from the next cycle and no fault is raised.
- Branch resolution (combinational, no memory interaction):
  - cond = bType 00 ? zero : 01 ? ~zero : 10 ? lt_zero : ~lt_zero.
  - pc_src = (branch & cond) | jump.
  - pc_target = jump_return ? {alu_result[31:1],1'b0} : branch_destination.
  - flush = pc_src.
- Store lanes:
  - Word store: dmem_wstrb = 1111, dmem_wdata = read_data_2.
  - Byte store: dmem_wdata = {4{read_data_2[7:0]}}, dmem_wstrb = 0001 << alu_result[1:0].
- Misalignment: a word access with alu_result[1:0] != 00 is misaligned.
  - No dmem_req, no stall.
  - mem_fault pulses for 1 cycle.
  - mem_read_data = 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If (memRead|memWrite) and the access is aligned: dmem_req = 1 combinationally, dmem_we = memWrite.
    - If dmem_ready = 1 in the same cycle: capture the read data and go to DONE; stall = 1.
    - Otherwise go to WAIT; stall = 1.
  - memRead and memWrite both high: treated as a store (memWrite wins).
- WAIT:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable, because EX/MEM is frozen by stall.
  - stall = 1; the counter increments each cycle.
  - dmem_ready = 1: capture the read data, go to DONE.
  - Counter reaches TIMEOUT without ready: drop dmem_req, pulse mem_fault, set the load register to 0, go to DONE.
- DONE:
  - stall = 0, dmem_req = 0, counter cleared.
  - mem_read_data = the load register, and the instruction advances into MEM/WB at the end of this cycle.
  - Go to IDLE unconditionally. The next instruction's access issues no earlier than the following cycle.
- Latency: a memory op with immediate ready costs 1 stall cycle; ready after N WAIT cycles costs N+1 stall cycles.
- Load extension, with byte b = dmem_rdata[8*alu_result[1:0] +: 8]:
  - Byte load: asUnsigned ? {24'b0,b} : {{24{b[7]}},b}.
  - Word load: dmem_rdata unchanged.
- Store completion: the load register is unchanged on stores; mem_read_data is don't-care for stores.
- Non-memory instructions: mem_read_data = 0.

Test Plan:
- bType=01, zero=0, branch=1, branch_destination=0x0000_0040 -> pc_src=1, pc_target=0x40, flush=1; with zero=1 -> pc_src=0.
- jump=1, jump_return=1, alu_result=0x0000_1003 -> pc_target=0x0000_1002, no dmem_req.
- lb with alu_result=0x0000_0102, dmem_rdata=0x12_80_34_56, ready after 2 WAIT cycles -> dmem_addr=0x100, stall high for 3 cycles, mem_read_data=0xFFFF_FF80 in DONE; the same access as lbu -> 0x0000_0080.
- sb with alu_result=0x0000_0203, read_data_2=0xAABB_CCDD -> dmem_wstrb=1000, dmem_wdata=0xDDDD_DDDD, dmem_we=1.
- lw at 0x0000_0006 -> no dmem_req, stall=0, mem_fault pulses once, mem_read_data=0.
- With TIMEOUT=4, dmem_ready held low -> stall for 5 cycles, mem_fault pulses once, then IDLE. Separately, assert rst during WAIT -> dmem_req=0 and stall=0 the next cycle, no fault.
